instr_con_unit: RTL and testbench
=================================

// Module: instr_con_unit
// PURPOSE
//   Instruction control unit: owns the program counter (PC) of the CPU fetch stage.
//   Each clock it advances PC sequentially, or loads an absolute JUMP target, or applies
//   a PC-relative BRANCH offset. PC drives the instruction memory address directly.
// PARAMETERS
//   PC_WIDTH  12      width of PC and imm (address space 2^PC_WIDTH words)
//   RESET_PC  0       PC value loaded while Reset is asserted
// PORTS
//   Clock   in   1         system clock, rising-edge active
//   Reset   in   1         asynchronous, active-low reset
//   BRANCH  in   1         take PC-relative branch this cycle (offset = imm)
//   JUMP    in   1         take absolute jump this cycle (target = imm)
//   imm     in   PC_WIDTH  jump target (unsigned) / branch offset (two's complement)
//   PC      out  PC_WIDTH  current program counter, registered
//   LINK    out  PC_WIDTH  return address, present only with INSTRCON_LINK_EN
// BEHAVIOUR
//   - One clock (Clock); reset is asynchronous and active-low (Reset); no other clock/reset.
//   - Reset==0: PC <= RESET_PC immediately, held while low; LINK <= RESET_PC.
//   - First rising edge after Reset deasserts performs a normal update.
//   - Next-PC priority, evaluated at each rising edge (single-cycle latency, no handshake):
//       1. JUMP==1            : PC <= imm
//       2. BRANCH==1 (JUMP==0): PC <= PC + sext(imm)   (offset relative to current PC)
//       3. otherwise          : PC <= PC + 1
//   - JUMP and BRANCH both high: JUMP wins; BRANCH ignored.
//   - All arithmetic modulo 2^PC_WIDTH: PC=max +1 wraps to 0; branch over/underflow wraps
//     silently (0x002 + 0xffd -> 0xfff). No carry/overflow flags.
//   - imm=0xfff with BRANCH = offset -1; imm=0 with BRANCH = self-loop (PC unchanged).
//   - X/undefined imm is don't-care when neither JUMP nor BRANCH is high.
//   - Reset asserted mid-operation overrides any pending JUMP/BRANCH asynchronously.
//   - PC is a pure register output; no combinational path from inputs to PC.
// CONFIGURATION
//   INSTRCON_LINK_EN defined: adds output LINK; on every edge with JUMP==1, LINK <= PC + 1
//     (wrapping), otherwise LINK holds. Supports call/return via software reading LINK.
//   INSTRCON_LINK_EN undefined: LINK port and register absent; PC behaviour identical.
// TESTING
//   - Reset low at t0, then high: PC==0x000 during reset; after 2 edges idle PC==0x002.
//   - JUMP=1 imm=0x5aa -> PC==0x5aa next edge; then imm=0x312 -> PC==0x312.
//   - From PC=0x312, BRANCH=1 imm=0x010 -> PC==0x322; then imm=0xfff -> PC==0x321.
//   - JUMP=1 and BRANCH=1, imm=0x100, PC=0x050 -> PC==0x100 (jump priority).
//   - JUMP to 0xfff, then idle -> PC==0x000 (wrap); BRANCH 0xffd from 0x002 -> 0xfff.
//   - Reset pulsed low mid-branch sequence -> PC==0x000 without waiting for an edge;
//     with INSTRCON_LINK_EN, JUMP from PC=0x123 -> LINK==0x124.

Source files
------------

// File: rtl/instr_con_unit.sv
// Instruction control unit: owns the fetch-stage program counter (jump / branch / increment).
// Optional return-address register LINK is built when INSTRCON_LINK_EN is defined.
module instr_con_unit #(
   parameter int unsigned             PC_WIDTH = 12,
   parameter logic [PC_WIDTH-1:0]     RESET_PC = '0
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                BRANCH,
   input  logic                JUMP,
   input  logic [PC_WIDTH-1:0] imm,
   output logic [PC_WIDTH-1:0] PC
`ifdef INSTRCON_LINK_EN
   ,
   output logic [PC_WIDTH-1:0] LINK
`endif
);

   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [PC_WIDTH-1:0] pc_inc;

   assign pc_inc = pc_q + PC_WIDTH'(1);

   // imm is as wide as PC, so a plain modulo add is the sign-extended branch offset
   always_comb begin
      pc_d = pc_inc;
      if (JUMP) begin
         pc_d = imm;
      end else if (BRANCH) begin
         pc_d = pc_q + imm;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign PC = pc_q;

`ifdef INSTRCON_LINK_EN
   logic [PC_WIDTH-1:0] link_q;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         link_q <= RESET_PC;
      end else if (JUMP) begin
         link_q <= pc_inc;
      end
   end

   assign LINK = link_q;
`endif

endmodule

// File: tb/tb_instr_con_unit.sv
// Self-checking bench for instr_con_unit: reset, table-driven next-PC vectors,
// asynchronous mid-operation reset and (with INSTRCON_LINK_EN) the LINK register.
module tb_instr_con_unit;

   localparam int unsigned W = 12;

   logic         Clock;
   logic         Reset;
   logic         BRANCH;
   logic         JUMP;
   logic [W-1:0] imm;
   logic [W-1:0] PC;
`ifdef INSTRCON_LINK_EN
   logic [W-1:0] LINK;
`endif

   int n_checks;
   int n_fail;

   instr_con_unit #(
      .PC_WIDTH (W),
      .RESET_PC (12'h000)
   ) dut (
      .Clock  (Clock),
      .Reset  (Reset),
      .BRANCH (BRANCH),
      .JUMP   (JUMP),
      .imm    (imm),
      .PC     (PC)
`ifdef INSTRCON_LINK_EN
      ,
      .LINK   (LINK)
`endif
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct {
      logic         jump;
      logic         branch;
      logic [W-1:0] imm;
      logic [W-1:0] exp_pc;
      string        name;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%03h expected 0x%03h", name, act, exp);
      end
   endtask

   // Wait for the active edge, then sample 1 time unit later.
   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic drive(input logic j, input logic b, input logic [W-1:0] i);
      JUMP   = j;
      BRANCH = b;
      imm    = i;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      Reset    = 1'b0;
      drive(1'b0, 1'b0, 12'h000);

      // Expected PCs continue from PC==0x002 after reset and two idle edges.
      vecs.push_back('{1'b1, 1'b0, 12'h5aa, 12'h5aa, "jump_5aa"});
      vecs.push_back('{1'b1, 1'b0, 12'h312, 12'h312, "jump_312"});
      vecs.push_back('{1'b0, 1'b1, 12'h010, 12'h322, "branch_fwd"});
      vecs.push_back('{1'b0, 1'b1, 12'hfff, 12'h321, "branch_minus1"});
      vecs.push_back('{1'b1, 1'b0, 12'h050, 12'h050, "jump_050"});
      vecs.push_back('{1'b1, 1'b1, 12'h100, 12'h100, "jump_priority"});
      vecs.push_back('{1'b1, 1'b0, 12'hfff, 12'hfff, "jump_fff"});
      vecs.push_back('{1'b0, 1'b0, 12'h000, 12'h000, "inc_wrap"});
      vecs.push_back('{1'b0, 1'b0, 12'h000, 12'h001, "inc_1"});
      vecs.push_back('{1'b0, 1'b0, 12'h000, 12'h002, "inc_2"});
      vecs.push_back('{1'b0, 1'b1, 12'hffd, 12'hfff, "branch_underflow"});
      vecs.push_back('{1'b0, 1'b1, 12'h000, 12'hfff, "branch_selfloop"});
      vecs.push_back('{1'b0, 1'b0, 12'habc, 12'h000, "idle_imm_ignored"});
      vecs.push_back('{1'b0, 1'b1, 12'h7ff, 12'h7ff, "branch_max_pos"});
      vecs.push_back('{1'b0, 1'b1, 12'h800, 12'hfff, "branch_max_neg"});
      vecs.push_back('{1'b0, 1'b1, 12'h003, 12'h002, "branch_overflow"});

      step();
      check("reset_held_edge1", PC, 12'h000);
      step();
      check("reset_held_edge2", PC, 12'h000);
`ifdef INSTRCON_LINK_EN
      check("link_reset", LINK, 12'h000);
`endif
      Reset = 1'b1;
      step();
      check("first_edge_inc", PC, 12'h001);
      step();
      check("second_edge_inc", PC, 12'h002);

      foreach (vecs[k]) begin
         drive(vecs[k].jump, vecs[k].branch, vecs[k].imm);
         step();
         check(vecs[k].name, PC, vecs[k].exp_pc);
      end

      // Asynchronous reset in the middle of a branch sequence.
      drive(1'b0, 1'b1, 12'h010);
      step();
      check("branch_before_reset", PC, 12'h012);
      #2;
      Reset = 1'b0;
      #1;
      check("async_reset_no_edge", PC, 12'h000);
      drive(1'b1, 1'b0, 12'h5aa);
      step();
      check("reset_overrides_jump", PC, 12'h000);
      Reset = 1'b1;
      drive(1'b0, 1'b1, 12'h010);
      step();
      check("branch_after_reset", PC, 12'h010);

`ifdef INSTRCON_LINK_EN
      drive(1'b1, 1'b0, 12'h123);
      step();
      check("link_jump_pc", PC, 12'h123);
      check("link_after_jump1", LINK, 12'h011);
      drive(1'b1, 1'b0, 12'h200);
      step();
      check("link_from_123", LINK, 12'h124);
      drive(1'b0, 1'b0, 12'h000);
      step();
      check("link_hold_idle", LINK, 12'h124);
      drive(1'b0, 1'b1, 12'h005);
      step();
      check("link_hold_branch", LINK, 12'h124);
      check("pc_after_link_seq", PC, 12'h206);
      drive(1'b1, 1'b0, 12'hfff);
      step();
      drive(1'b1, 1'b0, 12'h000);
      step();
      check("link_wrap", LINK, 12'h000);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
